btb_assoc: RTL and testbench
============================

Name: btb_assoc

Overview:
- N-way set-associative branch target buffer. Successor to the single-column direct-mapped BTB storage.
- Adds tags, per-entry valid bits, tree-PLRU replacement, a registered lookup pipeline, global flush and asynchronous reset.
- Sits in the fetch stage: fetch sends a PC index and tag, and one cycle later receives hit/target. The branch-resolve stage writes through the update port.

Parameters:
- width, 32: branch target width in bits.
- idx_width, 6: set index width.
- n_sets, 2**idx_width: number of sets (derived; do not override).
- tag_width, 24: stored tag width.
- n_ways, 4: associativity. Power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- lookup_valid  in  1  lookup request this cycle.
- lookup_idx  in  idx_width  set index of the request.
- lookup_tag  in  tag_width  tag of the request.
- resp_valid  out  1  response valid; registered copy of lookup_valid.
- resp_hit  out  1  a valid entry in the requested set matched the tag.
- resp_target  out  width  target of the hitting way; 0 when not a hit.
- upd_valid  in  1  write/refresh an entry.
- upd_idx  in  idx_width  set to update.
- upd_tag  in  tag_width  tag to write.
- upd_target  in  width  target to write.
- flush  in  1  invalidate every entry.

Behaviour:
- Reset (rst_n low, takes effect immediately, independent of clk):
  - all valid bits 0, all PLRU bits 0, resp_valid 0, registered request idx/tag 0.
  - Tag/target arrays are not reset.
  - Outputs during reset: resp_hit 0, resp_target 0.
- Lookup, latency 1:
  - A request sampled at edge E sets resp_valid=1 for the cycle after E.
  - resp_hit/resp_target are combinational compares of the registered idx/tag against array state after edge E.
  - An update or flush accepted at edge E is therefore visible in that response (write-before-read).
  - An update in the response cycle itself is not visible.
- Outputs when resp_valid=0: resp_hit 0, resp_target 0.
- Multiple matching ways cannot occur, by construction.
- Update, at the edge where upd_valid=1. Way selection, in order:
  - a valid way in upd_idx with tag == upd_tag: overwrite its target in place;
  - else the lowest-numbered invalid way;
  - else the PLRU victim.
  - Then set valid=1, write tag and target, and mark the way most-recently-used.
- PLRU: tree-PLRU with n_ways-1 bits per set.
  - Bit convention: 0 = evict left/lower half.
  - Touch way w: set every node on w's path to point away from w.
  - Touch sources:
    - a response-cycle hit touches the hit way at the following edge;
    - an update touches its written way at its own edge.
  - Same set touched by both in one cycle: apply the hit touch first, then the update touch (update wins).
- Flush, at the edge where flush=1:
  - clear all valid bits and all PLRU bits;
  - discard any concurrent update;
  - the pending registered lookup stays valid and reports a miss.
- Flush and reset do not drop resp_valid except via rst_n itself.
- No stalls, no backpressure: one lookup and one update accepted every cycle.

Decomposition:
- Package btb_pkg: typedefs btb_entry_t {valid, tag, target}, plru_t (logic [n_ways-2:0]), way index type, and a localparam for way index width ($clog2(n_ways)).
- One sub-module, btb_plru: combinational, parametrised by n_ways.
  - Inputs: current PLRU bits, touch way, touch enable.
  - Outputs: victim way and next PLRU bits.
  - Instantiated twice per cycle: hit-touch path chained into update-touch path.
- Storage stays in btb_assoc as flop arrays indexed [n_sets][n_ways].

Test Plan:
1. Release rst_n; lookup idx=5 tag=0x000123 -> next cycle resp_valid=1, resp_hit=0, resp_target=0.
2. Same cycle: upd idx=5 tag=0x000123 target=0x80000040 and lookup of the same idx/tag -> next cycle resp_hit=1, resp_target=0x80000040. Then upd the same idx/tag with target=0x80000100 -> lookup returns 0x80000100, and fills of 3 new tags in set 5 still hit on all 4 tags (no duplicate).
3. Set 3:
   - Fill tags A,B,C,D (ways 0..3), then lookup A (hit).
   - Insert E -> way 2 (C) evicted.
   - Lookups: C misses; A, B, D, E hit.
4. Flush in the same cycle as an upd to idx=7 -> all subsequent lookups miss, including idx=7. An in-flight lookup responds resp_valid=1, resp_hit=0.
5. Simultaneous response hit on set 3 way 0 and update to set 3 -> PLRU reflects the update touch last; check by the next victim choice against a reference model.
6. Assert rst_n low mid-cycle while resp_valid=1 -> resp_valid/resp_hit drop to 0 without a clock edge. After release, previously written entries miss.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types and sizing for the set-associative branch target buffer.
package btb_pkg;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned IDX_WIDTH = 6;
  localparam int unsigned TAG_WIDTH = 24;
  localparam int unsigned N_WAYS    = 4;
  localparam int unsigned WAY_W     = $clog2(N_WAYS);

  typedef logic [WAY_W-1:0]  way_t;
  typedef logic [N_WAYS-2:0] plru_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_WIDTH-1:0] tag;
    logic [WIDTH-1:0]     target;
  } btb_entry_t;

endpackage

// File: rtl/btb_plru.sv
// Tree-PLRU helper: victim selection and touch update for one set.
// Nodes are heap-ordered (children of i are 2i+1, 2i+2); a 0 bit points the victim left.
module btb_plru #(
  parameter int unsigned n_ways = 4
) (
  input  logic [n_ways-2:0]         plru_i,
  input  logic [$clog2(n_ways)-1:0] touch_way_i,
  input  logic                      touch_en_i,
  output logic [$clog2(n_ways)-1:0] victim_o,
  output logic [n_ways-2:0]         plru_o
);

  localparam int unsigned WAY_W = $clog2(n_ways);

  // Walk from the root following the bits; each step contributes one way bit, MSB first.
  always_comb begin
    logic [WAY_W-1:0] node;
    node     = '0;
    victim_o = '0;
    for (int unsigned l = 0; l < WAY_W; l++) begin
      victim_o[WAY_W-1-l] = plru_i[node];
      node = WAY_W'(2 * 32'(node) + 32'd1 + 32'(plru_i[node]));
    end
  end

  // Every node on the touched way's path is set to point at the other subtree.
  always_comb begin
    logic [WAY_W-1:0] node;
    logic             dir;
    node   = '0;
    dir    = 1'b0;
    plru_o = plru_i;
    if (touch_en_i) begin
      for (int unsigned l = 0; l < WAY_W; l++) begin
        dir          = touch_way_i[WAY_W-1-l];
        plru_o[node] = ~dir;
        node = WAY_W'(2 * 32'(node) + 32'd1 + 32'(dir));
      end
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// N-way set-associative branch target buffer with tree-PLRU replacement.
// Lookup responds one cycle after the request; updates and flush are write-before-read.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int unsigned width     = WIDTH,
  parameter int unsigned idx_width = IDX_WIDTH,
  parameter int unsigned tag_width = TAG_WIDTH,
  parameter int unsigned n_ways    = N_WAYS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lookup_valid,
  input  logic [idx_width-1:0] lookup_idx,
  input  logic [tag_width-1:0] lookup_tag,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic [width-1:0]     resp_target,
  input  logic                 upd_valid,
  input  logic [idx_width-1:0] upd_idx,
  input  logic [tag_width-1:0] upd_tag,
  input  logic [width-1:0]     upd_target,
  input  logic                 flush
);

  localparam int unsigned n_sets = 2 ** idx_width;

  logic [n_sets-1:0][n_ways-1:0] valid_q, valid_d;
  plru_t [n_sets-1:0]            plru_q, plru_d;
  logic [tag_width-1:0]          tag_q [n_sets][n_ways];
  logic [width-1:0]              tgt_q [n_sets][n_ways];

  logic                 resp_valid_q;
  logic [idx_width-1:0] req_idx_q;
  logic [tag_width-1:0] req_tag_q;

  btb_entry_t rd_ent [n_ways];
  logic       hit_any;
  way_t       hit_way;

  plru_t hit_plru_next;
  way_t  hit_victim_unused;
  plru_t upd_plru_src;
  plru_t upd_plru_next;
  way_t  upd_victim;

  logic  upd_match;
  way_t  upd_match_way;
  logic  inv_found;
  way_t  inv_way;
  way_t  upd_way;

  // Response: compare registered request against the array as it stands after the edge.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < int'(n_ways); w++) begin
      rd_ent[w].valid  = valid_q[req_idx_q][w];
      rd_ent[w].tag    = tag_q[req_idx_q][w];
      rd_ent[w].target = tgt_q[req_idx_q][w];
    end
    for (int w = int'(n_ways) - 1; w >= 0; w--) begin
      if (rd_ent[w].valid && (rd_ent[w].tag == req_tag_q)) begin
        hit_any = 1'b1;
        hit_way = way_t'(w);
      end
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_hit    = resp_valid_q & hit_any;
  assign resp_target = resp_hit ? rd_ent[hit_way].target : '0;

  btb_plru #(.n_ways(n_ways)) u_plru_hit (
    .plru_i      (plru_q[req_idx_q]),
    .touch_way_i (hit_way),
    .touch_en_i  (resp_hit),
    .victim_o    (hit_victim_unused),
    .plru_o      (hit_plru_next)
  );

  // Update sees the hit touch first when both target the same set.
  assign upd_plru_src = (resp_hit && (upd_idx == req_idx_q)) ? hit_plru_next : plru_q[upd_idx];

  btb_plru #(.n_ways(n_ways)) u_plru_upd (
    .plru_i      (upd_plru_src),
    .touch_way_i (upd_way),
    .touch_en_i  (upd_valid),
    .victim_o    (upd_victim),
    .plru_o      (upd_plru_next)
  );

  // Way choice: matching tag, else lowest invalid way, else PLRU victim.
  always_comb begin
    upd_match     = 1'b0;
    upd_match_way = '0;
    inv_found     = 1'b0;
    inv_way       = '0;
    for (int w = int'(n_ways) - 1; w >= 0; w--) begin
      if (valid_q[upd_idx][w] && (tag_q[upd_idx][w] == upd_tag)) begin
        upd_match     = 1'b1;
        upd_match_way = way_t'(w);
      end
      if (!valid_q[upd_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = way_t'(w);
      end
    end
    if (upd_match) begin
      upd_way = upd_match_way;
    end else if (inv_found) begin
      upd_way = inv_way;
    end else begin
      upd_way = upd_victim;
    end
  end

  always_comb begin
    valid_d = valid_q;
    plru_d  = plru_q;
    if (flush) begin
      valid_d = '0;
      plru_d  = '0;
    end else begin
      if (resp_hit) begin
        plru_d[req_idx_q] = hit_plru_next;
      end
      if (upd_valid) begin
        valid_d[upd_idx][upd_way] = 1'b1;
        plru_d[upd_idx]           = upd_plru_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= '0;
      plru_q       <= '0;
      resp_valid_q <= 1'b0;
      req_idx_q    <= '0;
      req_tag_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      plru_q       <= plru_d;
      resp_valid_q <= lookup_valid;
      req_idx_q    <= lookup_idx;
      req_tag_q    <= lookup_tag;
    end
  end

  // Tag and target arrays carry no reset; valid bits gate their contents.
  always_ff @(posedge clk) begin
    if (upd_valid && !flush) begin
      tag_q[upd_idx][upd_way] <= upd_tag;
      tgt_q[upd_idx][upd_way] <= upd_target;
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc with a behavioural reference model and response scoreboard.
module tb_btb_assoc;

  logic        clk;
  logic        rst_n;
  logic        lookup_valid;
  logic [5:0]  lookup_idx;
  logic [23:0] lookup_tag;
  logic        resp_valid;
  logic        resp_hit;
  logic [31:0] resp_target;
  logic        upd_valid;
  logic [5:0]  upd_idx;
  logic [23:0] upd_tag;
  logic [31:0] upd_target;
  logic        flush;

  btb_assoc dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookup_valid (lookup_valid),
    .lookup_idx   (lookup_idx),
    .lookup_tag   (lookup_tag),
    .resp_valid   (resp_valid),
    .resp_hit     (resp_hit),
    .resp_target  (resp_target),
    .upd_valid    (upd_valid),
    .upd_idx      (upd_idx),
    .upd_tag      (upd_tag),
    .upd_target   (upd_target),
    .flush        (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    bit          h;
    logic [31:0] t;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  bit          m_valid [64][4];
  logic [23:0] m_tag   [64][4];
  logic [31:0] m_tgt   [64][4];
  logic [2:0]  m_plru  [64];
  bit          p_hit;
  int          p_idx;
  logic [1:0]  p_way;

  logic        s_v;
  logic        s_h;
  logic [31:0] s_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] m_victim(input logic [2:0] p);
    return p[0] ? {1'b1, p[2]} : {1'b0, p[1]};
  endfunction

  function automatic logic [2:0] m_touch(input logic [2:0] p, input logic [1:0] w);
    logic [2:0] r;
    r    = p;
    r[0] = ~w[1];
    if (w[1]) r[2] = ~w[0];
    else      r[1] = ~w[0];
    return r;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 64; s++) begin
      m_plru[s] = 3'b000;
      for (int w = 0; w < 4; w++) m_valid[s][w] = 1'b0;
    end
    p_hit = 1'b0;
    sb.delete();
  endtask

  // Applies one clock edge's worth of inputs to the model and queues the expected response.
  task automatic model_edge();
    exp_t       e;
    bit         found;
    logic [1:0] w_sel;
    if (p_hit) m_plru[p_idx] = m_touch(m_plru[p_idx], p_way);
    if (flush) begin
      for (int s = 0; s < 64; s++) begin
        m_plru[s] = 3'b000;
        for (int w = 0; w < 4; w++) m_valid[s][w] = 1'b0;
      end
    end else if (upd_valid) begin
      found = 1'b0;
      w_sel = 2'd0;
      for (int w = 0; w < 4; w++)
        if (!found && m_valid[upd_idx][w] && m_tag[upd_idx][w] == upd_tag) begin
          found = 1'b1; w_sel = 2'(w);
        end
      for (int w = 0; w < 4; w++)
        if (!found && !m_valid[upd_idx][w]) begin
          found = 1'b1; w_sel = 2'(w);
        end
      if (!found) w_sel = m_victim(m_plru[upd_idx]);
      m_valid[upd_idx][w_sel] = 1'b1;
      m_tag[upd_idx][w_sel]   = upd_tag;
      m_tgt[upd_idx][w_sel]   = upd_target;
      m_plru[upd_idx]         = m_touch(m_plru[upd_idx], w_sel);
    end
    e.v = lookup_valid;
    e.h = 1'b0;
    e.t = 32'h0;
    p_hit = 1'b0;
    if (lookup_valid) begin
      for (int w = 0; w < 4; w++)
        if (m_valid[lookup_idx][w] && m_tag[lookup_idx][w] == lookup_tag) begin
          e.h = 1'b1; e.t = m_tgt[lookup_idx][w];
          p_hit = 1'b1; p_idx = int'(lookup_idx); p_way = 2'(w);
        end
    end
    sb.push_back(e);
  endtask

  task automatic step(input bit lv, input logic [5:0] li, input logic [23:0] lt,
                      input bit uv, input logic [5:0] ui, input logic [23:0] ut,
                      input logic [31:0] utg, input bit fl);
    exp_t e;
    lookup_valid = lv; lookup_idx = li; lookup_tag = lt;
    upd_valid = uv; upd_idx = ui; upd_tag = ut; upd_target = utg;
    flush = fl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    s_v = resp_valid; s_h = resp_hit; s_t = resp_target;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("sb_resp_valid", 32'(s_v), 32'(e.v));
      chk("sb_resp_hit", 32'(s_h), 32'(e.h));
      chk("sb_resp_target", s_t, e.t);
    end
  endtask

  task automatic lookup(input logic [5:0] i, input logic [23:0] t);
    step(1'b1, i, t, 1'b0, 6'd0, 24'd0, 32'd0, 1'b0);
  endtask

  task automatic update(input logic [5:0] i, input logic [23:0] t, input logic [31:0] g);
    step(1'b0, 6'd0, 24'd0, 1'b1, i, t, g, 1'b0);
  endtask

  task automatic expect_resp(input string name, input bit h, input logic [31:0] t);
    chk({name, "_valid"}, 32'(s_v), 32'd1);
    chk({name, "_hit"}, 32'(s_h), 32'(h));
    chk({name, "_target"}, s_t, t);
  endtask

  initial begin
    rst_n = 1'b1;
    lookup_valid = 1'b0; lookup_idx = '0; lookup_tag = '0;
    upd_valid = 1'b0; upd_idx = '0; upd_tag = '0; upd_target = '0;
    flush = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #11;
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_resp_hit", 32'(resp_hit), 32'd0);
    chk("reset_resp_target", resp_target, 32'd0);
    rst_n = 1'b1;

    // Cold miss, then write-before-read hit and in-place refresh
    lookup(6'd5, 24'h000123);
    expect_resp("t1_cold", 1'b0, 32'h0);
    step(1'b1, 6'd5, 24'h000123, 1'b1, 6'd5, 24'h000123, 32'h80000040, 1'b0);
    expect_resp("t2_wbr", 1'b1, 32'h80000040);
    update(6'd5, 24'h000123, 32'h80000100);
    lookup(6'd5, 24'h000123);
    expect_resp("t2_refresh", 1'b1, 32'h80000100);
    update(6'd5, 24'h000456, 32'h00004560);
    update(6'd5, 24'h000789, 32'h00007890);
    update(6'd5, 24'h000abc, 32'h0000abc0);
    lookup(6'd5, 24'h000123); expect_resp("t2_s5_a", 1'b1, 32'h80000100);
    lookup(6'd5, 24'h000456); expect_resp("t2_s5_b", 1'b1, 32'h00004560);
    lookup(6'd5, 24'h000789); expect_resp("t2_s5_c", 1'b1, 32'h00007890);
    lookup(6'd5, 24'h000abc); expect_resp("t2_s5_d", 1'b1, 32'h0000abc0);

    // Set 3: fill, touch way 0, insert E -> way 2 evicted
    update(6'd3, 24'h00000a, 32'h0000a000);
    update(6'd3, 24'h00000b, 32'h0000b000);
    update(6'd3, 24'h00000c, 32'h0000c000);
    update(6'd3, 24'h00000d, 32'h0000d000);
    lookup(6'd3, 24'h00000a); expect_resp("t3_a_first", 1'b1, 32'h0000a000);
    update(6'd3, 24'h00000e, 32'h0000e000);
    lookup(6'd3, 24'h00000c); expect_resp("t3_c_evicted", 1'b0, 32'h0);
    lookup(6'd3, 24'h00000a); expect_resp("t3_a", 1'b1, 32'h0000a000);
    lookup(6'd3, 24'h00000b); expect_resp("t3_b", 1'b1, 32'h0000b000);
    lookup(6'd3, 24'h00000d); expect_resp("t3_d", 1'b1, 32'h0000d000);
    lookup(6'd3, 24'h00000e); expect_resp("t3_e", 1'b1, 32'h0000e000);

    // Flush with concurrent update and in-flight lookup
    update(6'd7, 24'h000777, 32'h00077700);
    step(1'b1, 6'd7, 24'h000777, 1'b1, 6'd7, 24'h000777, 32'h00077701, 1'b1);
    expect_resp("t4_inflight", 1'b0, 32'h0);
    lookup(6'd7, 24'h000777); expect_resp("t4_idx7", 1'b0, 32'h0);
    lookup(6'd5, 24'h000123); expect_resp("t4_idx5", 1'b0, 32'h0);
    lookup(6'd3, 24'h00000a); expect_resp("t4_idx3", 1'b0, 32'h0);

    // Response hit on set 3 way 0 coinciding with an update to set 3
    update(6'd3, 24'h000100, 32'h00010000);
    update(6'd3, 24'h000101, 32'h00010100);
    update(6'd3, 24'h000102, 32'h00010200);
    update(6'd3, 24'h000103, 32'h00010300);
    lookup(6'd3, 24'h000100); expect_resp("t5_hit_w0", 1'b1, 32'h00010000);
    update(6'd3, 24'h000104, 32'h00010400);
    update(6'd3, 24'h000105, 32'h00010500);
    lookup(6'd3, 24'h000100); expect_resp("t5_t0", 1'b1, 32'h00010000);
    lookup(6'd3, 24'h000101); expect_resp("t5_t1_evicted", 1'b0, 32'h0);
    lookup(6'd3, 24'h000102); expect_resp("t5_t2_evicted", 1'b0, 32'h0);
    lookup(6'd3, 24'h000103); expect_resp("t5_t3", 1'b1, 32'h00010300);
    lookup(6'd3, 24'h000104); expect_resp("t5_t4", 1'b1, 32'h00010400);
    lookup(6'd3, 24'h000105); expect_resp("t5_t5", 1'b1, 32'h00010500);

    // Asynchronous reset mid-cycle while a hit response is showing
    lookup(6'd3, 24'h000103); expect_resp("t6_pre", 1'b1, 32'h00010300);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(resp_valid), 32'd0);
    chk("t6_async_hit", 32'(resp_hit), 32'd0);
    chk("t6_async_target", resp_target, 32'd0);
    #2 rst_n = 1'b1;
    model_reset();
    lookup(6'd3, 24'h000103); expect_resp("t6_post_s3", 1'b0, 32'h0);
    lookup(6'd5, 24'h000123); expect_resp("t6_post_s5", 1'b0, 32'h0);
    step(1'b0, 6'd0, 24'd0, 1'b0, 6'd0, 24'd0, 32'd0, 1'b0);
    chk("idle_valid", 32'(s_v), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
